// File: rtl/clock_gate_pkg.sv
// Shared types for the clock-gate enable sequencer: FSM state encoding and stats width.
package clock_gate_pkg;

  typedef enum logic [1:0] {
    OFF       = 2'd0,
    WAKE      = 2'd1,
    ON        = 2'd2,
    IDLE_WAIT = 2'd3
  } state_e;

  localparam int STATS_W = 32;

endpackage

// File: rtl/clock_gate_ctrl_if.sv
// Requester-side bundle of the clock-gate controller: per-requester req/ack plus gate status.
interface clock_gate_ctrl_if import clock_gate_pkg::*; #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0] i_req;
  logic [NUM_REQ-1:0] o_ack;
  logic               o_clock_en;
  logic               o_busy;
  logic [STATS_W-1:0] o_on_cycles;

  modport master (output i_req, input o_ack, o_clock_en, o_busy, o_on_cycles);
  modport slave  (input i_req, output o_ack, o_clock_en, o_busy, o_on_cycles);
endinterface

// File: rtl/gate_down_cnt.sv
// Loadable down-counter that parks at zero; used for the wake and idle timers.
module gate_down_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                        cnt_q <= '0;
    else if (load_i)                  cnt_q <= load_val_i;
    else if (dec_i && cnt_q != '0)    cnt_q <= cnt_q - 1'b1;
  end

  assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/clock_gate_ctrl.sv
// Gated-clock enable sequencer with wake settling and idle hysteresis.
// Define CLOCK_GATE_CTRL_STATS_EN to build the saturating on-cycle counter.
module clock_gate_ctrl import clock_gate_pkg::*; #(
  parameter int NUM_REQ     = 4,
  parameter int WAKE_CYCLES = 2,
  parameter int IDLE_CYCLES = 8,
  parameter int CNT_W       = 8
) (
  input  logic             i_clock,
  input  logic             i_reset,
  clock_gate_ctrl_if.slave bus
);
  localparam logic [CNT_W-1:0] WAKE_LD = CNT_W'((WAKE_CYCLES > 0) ? WAKE_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] IDLE_LD = CNT_W'(IDLE_CYCLES - 1);

  if (WAKE_CYCLES < 0 || WAKE_CYCLES >= (1 << CNT_W) ||
      IDLE_CYCLES < 1 || IDLE_CYCLES >= (1 << CNT_W)) begin : g_bad_cfg
    $error("clock_gate_ctrl: WAKE_CYCLES/IDLE_CYCLES do not fit CNT_W");
  end

  state_e             state_q, state_d;
  logic               clock_en_q, busy_q;
  logic [NUM_REQ-1:0] ack_q;
  logic               wake_load, wake_dec, wake_zero;
  logic               idle_load, idle_dec, idle_zero;
  logic               any_req;

  assign any_req = |bus.i_req;

  gate_down_cnt #(.CNT_W(CNT_W)) u_wake_cnt (
    .clk_i(i_clock), .rst_i(i_reset), .load_i(wake_load),
    .load_val_i(WAKE_LD), .dec_i(wake_dec), .zero_o(wake_zero)
  );

  gate_down_cnt #(.CNT_W(CNT_W)) u_idle_cnt (
    .clk_i(i_clock), .rst_i(i_reset), .load_i(idle_load),
    .load_val_i(IDLE_LD), .dec_i(idle_dec), .zero_o(idle_zero)
  );

  always_comb begin
    state_d   = state_q;
    wake_load = 1'b0;
    wake_dec  = 1'b0;
    idle_load = 1'b0;
    idle_dec  = 1'b0;
    case (state_q)
      OFF: if (any_req) begin
        if (WAKE_CYCLES == 0) state_d = ON;
        else begin
          state_d   = WAKE;
          wake_load = 1'b1;
        end
      end
      // Wake completes regardless of requests; ON then falls into idle on its own.
      WAKE: if (wake_zero) state_d = ON;
            else           wake_dec = 1'b1;
      ON: if (!any_req) begin
        state_d   = IDLE_WAIT;
        idle_load = 1'b1;
      end
      // A request on the expiry cycle wins over gating off.
      IDLE_WAIT: if (any_req)        state_d = ON;
                 else if (idle_zero) state_d = OFF;
                 else                idle_dec = 1'b1;
      default: state_d = OFF;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= OFF;
      clock_en_q <= 1'b0;
      busy_q     <= 1'b0;
      ack_q      <= '0;
    end else begin
      state_q    <= state_d;
      clock_en_q <= (state_d != OFF);
      busy_q     <= (state_d != OFF);
      ack_q      <= bus.i_req & {NUM_REQ{state_d == ON}};
    end
  end

  assign bus.o_ack      = ack_q;
  assign bus.o_clock_en = clock_en_q;
  assign bus.o_busy     = busy_q;

`ifdef CLOCK_GATE_CTRL_STATS_EN
  logic [STATS_W-1:0] on_cnt_q;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset)                              on_cnt_q <= '0;
    else if (clock_en_q && on_cnt_q != '1)    on_cnt_q <= on_cnt_q + 1'b1;
  end

  assign bus.o_on_cycles = on_cnt_q;
`else
  assign bus.o_on_cycles = '0;
`endif
endmodule

// File: tb/tb_clock_gate_ctrl.sv
// Directed plus random bench for clock_gate_ctrl against a timestamp-based reference model.
module tb_clock_gate_ctrl;
  import clock_gate_pkg::*;

  localparam int NR = 4;
  localparam int WK = 2;
  localparam int ID = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  clock_gate_ctrl_if #(.NUM_REQ(NR)) bus ();

  clock_gate_ctrl #(.NUM_REQ(NR), .WAKE_CYCLES(WK), .IDLE_CYCLES(ID), .CNT_W(8)) dut (
    .i_clock(clk),
    .i_reset(rst),
    .bus    (bus)
  );

  int errors = 0;
  int checks = 0;

  // Model: the gate is "on" from the first request until IDLE+1 edges after the
  // later of the last request edge and the wake-complete edge.
  int            edge_n   = 0;
  bit            m_on     = 1'b0;
  int            ready_at = 0;
  int            anchor   = 0;
  longint        m_cnt    = 0;
  logic [NR-1:0] m_ack    = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_on  = 1'b0;
    m_cnt = 0;
    m_ack = '0;
  endtask

  task automatic model_edge(input logic [NR-1:0] r);
    edge_n++;
    if (m_on && m_cnt < 64'hFFFF_FFFF) m_cnt++;
    if (!m_on) begin
      if (r != '0) begin
        m_on     = 1'b1;
        ready_at = edge_n + WK;
        anchor   = ready_at;
      end
    end else if (r != '0) begin
      if (edge_n > anchor) anchor = edge_n;
    end else if (edge_n >= anchor + ID + 1) begin
      m_on = 1'b0;
    end
    m_ack = (m_on && edge_n >= ready_at) ? r : '0;
  endtask

  task automatic check_all(input string tag);
    logic [31:0] exp_stats;
`ifdef CLOCK_GATE_CTRL_STATS_EN
    exp_stats = 32'(m_cnt);
`else
    exp_stats = 32'd0;
`endif
    chk({tag, ".en"},    32'(bus.o_clock_en), 32'(m_on));
    chk({tag, ".busy"},  32'(bus.o_busy),     32'(m_on));
    chk({tag, ".ack"},   32'(bus.o_ack),      32'(m_ack));
    chk({tag, ".stats"}, bus.o_on_cycles,     exp_stats);
  endtask

  // Entry/exit point: 1 time unit after a rising edge.
  task automatic step(input logic [NR-1:0] r, input string tag);
    @(negedge clk);
    bus.i_req = r;
    @(posedge clk);
    model_edge(r);
    #1;
    check_all(tag);
  endtask

  task automatic pulse_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    bus.i_req = '0;
    @(posedge clk);
    #1;
    check_all("reset");
    rst = 1'b0;
    step('0, "idle0");
    step('0, "idle1");

    // Cold wake and hold
    for (int i = 0; i < 12; i++) begin
      step(4'b0010, "cold");
      if (i == 0) chk("cold.en_first", 32'(bus.o_clock_en), 32'd1);
      if (i == 1) chk("cold.ack_early", 32'(bus.o_ack), 32'd0);
      if (i == 2) chk("cold.ack_third", 32'(bus.o_ack), 32'b0010);
    end

    // Idle gate-off
    for (int i = 0; i < 9; i++) begin
      step('0, "gateoff");
      if (i == 0) chk("gateoff.ack_drop", 32'(bus.o_ack), 32'd0);
      if (i == 7) chk("gateoff.en_held", 32'(bus.o_clock_en), 32'd1);
      if (i == 8) chk("gateoff.en_off", 32'(bus.o_clock_en), 32'd0);
    end

    // Idle rescue on the 5th IDLE_WAIT cycle
    for (int i = 0; i < 5; i++) step(4'b0001, "rescue.wake");
    for (int i = 0; i < 4; i++) step('0, "rescue.idle");
    step(4'b1000, "rescue.req");
    chk("rescue.ack", 32'(bus.o_ack), 32'b1000);
    chk("rescue.en",  32'(bus.o_clock_en), 32'd1);

    // Request lands on the idle-expiry cycle
    step(4'b1000, "race.hold");
    for (int i = 0; i < 8; i++) step('0, "race.idle");
    step(4'b0100, "race.req");
    chk("race.en",  32'(bus.o_clock_en), 32'd1);
    chk("race.ack", 32'(bus.o_ack), 32'b0100);

    // Concurrent requesters, then asynchronous reset mid-cycle
    for (int i = 0; i < 3; i++) step(4'b1111, "conc");
    chk("conc.ack", 32'(bus.o_ack), 32'b1111);
    #2;
    rst = 1'b1;
    #1;
    chk("async.en",   32'(bus.o_clock_en), 32'd0);
    chk("async.ack",  32'(bus.o_ack),      32'd0);
    chk("async.busy", 32'(bus.o_busy),     32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(4'b1111, "rewake");
      if (i == 1) chk("rewake.ack_early", 32'(bus.o_ack), 32'd0);
      if (i == 2) chk("rewake.ack", 32'(bus.o_ack), 32'b1111);
    end

    // 20-cycle ON session for the stats counter
    for (int i = 0; i < 20; i++) step(4'b1111, "session");
    for (int i = 0; i < 10; i++) step('0, "session.off");

    // Random bursts and gaps, with occasional resets
    for (int b = 0; b < 60; b++) begin
      logic [NR-1:0] r;
      int            len;
      r   = NR'($urandom_range(1, (1 << NR) - 1));
      len = $urandom_range(1, 12);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0) r = NR'($urandom_range(0, (1 << NR) - 1));
        step(r, "rand.busy");
      end
      len = $urandom_range(1, 14);
      for (int i = 0; i < len; i++) step('0, "rand.gap");
      if ($urandom_range(0, 19) == 0) pulse_reset("rand.reset");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
